instr_fetch: RTL and testbench

- Fetch stage directly downstream of the program counter.
- Reads the current PC value and issues one read at a time to instruction memory over a req/ack handshake. Buffers returned instructions in a small FIFO and presents them to the decoder with valid/ready.
- Drives the PC's enable and branch controls: increments the PC after each completed fetch and loads a redirect target on a taken branch from execute, flushing stale work.

---
 rtl/instr_fetch.sv | 132 +++++++++++++
 tb/tb_instr_fetch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage between the program counter and instruction memory.
// Keeps one read outstanding and queues returned words for the decoder.
module instr_fetch #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_en,
  output logic              pc_branch_en,
  output logic [ADDR_W-1:0] pc_branch_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_addr
);

  // state | meaning
  // IDLE  | nothing outstanding; issue a read when the FIFO has room
  // WAIT  | read outstanding, returned word will be queued
  // DROP  | read outstanding, returned word is stale and discarded

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              has_room, issue, push, pop;

  assign has_room = (count < FULL_CNT);
  assign pop      = instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (!redirect && has_room) state_nxt = S_WAIT;
      S_WAIT: begin
        if (redirect)     state_nxt = S_DROP;
        else if (mem_ack) state_nxt = S_IDLE;
      end
      S_DROP: if (!redirect && mem_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    issue          = 1'b0;
    push           = 1'b0;
    pc_en          = 1'b0;
    pc_branch_en   = 1'b0;
    pc_branch_addr = '0;
    case (state)
      S_IDLE:  issue = !redirect && has_room;
      S_WAIT:  push  = mem_ack && !redirect;
      default: ;
    endcase
    if (redirect) pc_branch_addr = redirect_addr;
    // PC controls are held off for the whole time reset is asserted
    if (rst) begin
      pc_en        = redirect || push;
      pc_branch_en = redirect;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else if (issue) begin
      mem_req  <= 1'b1;
      mem_addr <= pc_addr;
    end else if (state_nxt == S_IDLE) begin
      mem_req  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= mem_rdata;
      addr_q[wr_ptr] <= mem_addr;
    end
  end

  assign instr_valid = (count != '0);
  assign instr_data  = data_q[rd_ptr];
  assign instr_addr  = addr_q[rd_ptr];

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed fetch scenarios; a scoreboard checks issued read
// addresses and delivered instructions against hand-computed expectations.
module tb_instr_fetch;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } instr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] pc;
  logic              pc_en, pc_branch_en;
  logic [ADDR_W-1:0] pc_branch_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic              instr_valid, instr_ready;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_addr;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;

  logic [ADDR_W-1:0] exp_mem [$];
  instr_t            exp_instr [$];
  instr_t            mon_e;
  logic [ADDR_W-1:0] mon_a;
  int cmp_cnt = 0;
  int err_cnt = 0;
  int incr_cnt = 0;
  int ack_grant = 0;
  int acks_done = 0;
  int snap = 0;
  logic req_prev = 1'b0;

  always #5 clk = ~clk;

  // Program counter model driven by the DUT's enable/branch controls
  always @(posedge clk) begin
    if (pc_load)     pc <= pc_load_val;
    else if (pc_en)  pc <= pc_branch_en ? pc_branch_addr : pc + 8'd1;
  end

  instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc),
    .pc_en(pc_en), .pc_branch_en(pc_branch_en), .pc_branch_addr(pc_branch_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_addr(instr_addr)
  );

  function automatic logic [DATA_W-1:0] dat(input logic [ADDR_W-1:0] a);
    return {~a, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_instr(input logic [ADDR_W-1:0] a);
    instr_t e;
    e.addr = a;
    e.data = dat(a);
    exp_instr.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_mem.size() != 0 || exp_instr.size() != 0) && n < 60) begin
      @(negedge clk); #3;
      n++;
    end
    chk(name, 32'(exp_mem.size() + exp_instr.size()), 32'd0);
    exp_mem.delete();
    exp_instr.delete();
  endtask

  initial begin
    rst = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_addr = '0;
    pc_load = 1'b1; pc_load_val = '0; mem_ack = 1'b0; mem_rdata = '0;

    fork
      // memory: acks one cycle per granted read, data derived from address
      forever begin
        @(negedge clk); #1;
        if (mem_ack) mem_ack = 1'b0;
        else if (mem_req && acks_done < ack_grant) begin
          mem_ack   = 1'b1;
          mem_rdata = dat(mem_addr);
          acks_done++;
        end
      end
      // monitor: scoreboard on deliveries and issued addresses
      forever begin
        @(negedge clk); #2;
        if (instr_valid && instr_ready) begin
          if (exp_instr.size() == 0) begin
            cmp_cnt++; err_cnt++;
            $display("FAIL instr_unexpected: got addr %0h data %0h, expected none", instr_addr, instr_data);
          end else begin
            mon_e = exp_instr.pop_front();
            chk("instr_addr", 32'(instr_addr), 32'(mon_e.addr));
            chk("instr_data", 32'(instr_data), 32'(mon_e.data));
          end
        end
        if (mem_req && !req_prev) begin
          if (exp_mem.size() == 0) begin
            cmp_cnt++; err_cnt++;
            $display("FAIL issue_unexpected: got mem_addr %0h, expected none", mem_addr);
          end else begin
            mon_a = exp_mem.pop_front();
            chk("mem_addr", 32'(mem_addr), 32'(mon_a));
          end
        end
        req_prev = mem_req;
        if (pc_en && !pc_branch_en) incr_cnt++;
      end
    join_none

    // reset
    @(negedge clk); #3;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    redirect = 1'b1; redirect_addr = 8'h33;
    #3;
    chk("rst_pc_en", 32'(pc_en), 32'd0);
    chk("rst_pc_branch_en", 32'(pc_branch_en), 32'd0);

    // streaming: fetch 0,1,2 delivered; read of 3 left waiting
    @(negedge clk);
    redirect = 1'b0; rst = 1'b1; pc_load = 1'b0; instr_ready = 1'b1;
    ack_grant += 3;
    snap = incr_cnt;
    exp_mem.push_back(8'h00); exp_mem.push_back(8'h01);
    exp_mem.push_back(8'h02); exp_mem.push_back(8'h03);
    expect_instr(8'h00); expect_instr(8'h01); expect_instr(8'h02);
    wait_drain("stream_drain");
    chk("stream_incr", 32'(incr_cnt - snap), 32'd3);
    chk("stream_wait_req", 32'(mem_req), 32'd1);
    chk("stream_wait_addr", 32'(mem_addr), 32'h03);

    // backpressure: FIFO fills with 3,4 and issue stops
    @(negedge clk);
    instr_ready = 1'b0; ack_grant += 2; snap = incr_cnt;
    exp_mem.push_back(8'h04);
    repeat (10) @(negedge clk);
    #3;
    chk("bp_req_idle", 32'(mem_req), 32'd0);
    chk("bp_valid", 32'(instr_valid), 32'd1);
    chk("bp_head_addr", 32'(instr_addr), 32'h03);
    chk("bp_head_data", 32'(instr_data), 32'(dat(8'h03)));
    chk("bp_issued", 32'(exp_mem.size()), 32'd0);
    @(negedge clk);
    instr_ready = 1'b1; ack_grant += 1;
    expect_instr(8'h03); expect_instr(8'h04); expect_instr(8'h05);
    exp_mem.push_back(8'h05); exp_mem.push_back(8'h06);
    wait_drain("bp_resume_drain");
    chk("bp_incr", 32'(incr_cnt - snap), 32'd3);

    // push and pop on the same edge with one entry held
    @(negedge clk);
    instr_ready = 1'b0; ack_grant += 1;
    exp_mem.push_back(8'h07);
    wait_drain("pp_setup");
    @(negedge clk);
    instr_ready = 1'b1; ack_grant += 1;
    expect_instr(8'h06);
    @(negedge clk);
    instr_ready = 1'b0;
    #3;
    chk("pp_valid", 32'(instr_valid), 32'd1);
    chk("pp_head_addr", 32'(instr_addr), 32'h07);
    chk("pp_head_data", 32'(instr_data), 32'(dat(8'h07)));
    exp_mem.push_back(8'h08);
    wait_drain("pp_next_issue");

    // redirect while read of 8 is outstanding; queued 7 is flushed
    @(negedge clk);
    redirect = 1'b1; redirect_addr = 8'h40; snap = incr_cnt;
    #3;
    chk("rd_pc_en", 32'(pc_en), 32'd1);
    chk("rd_branch_en", 32'(pc_branch_en), 32'd1);
    chk("rd_branch_addr", 32'(pc_branch_addr), 32'h40);
    @(negedge clk);
    redirect = 1'b0; instr_ready = 1'b1; ack_grant += 1;
    exp_mem.push_back(8'h40);
    #3;
    chk("rd_flushed", 32'(instr_valid), 32'd0);
    chk("rd_drop_req", 32'(mem_req), 32'd1);
    chk("rd_drop_pc_en", 32'(pc_en), 32'd0);
    chk("rd_branch_addr_idle", 32'(pc_branch_addr), 32'd0);
    wait_drain("rd_reissue");
    chk("rd_incr", 32'(incr_cnt - snap), 32'd0);

    // redirect coincident with ack of 0x40
    @(negedge clk);
    redirect = 1'b1; redirect_addr = 8'h80; ack_grant += 1; snap = incr_cnt;
    #3;
    chk("co_pc_en", 32'(pc_en), 32'd1);
    chk("co_branch_addr", 32'(pc_branch_addr), 32'h80);
    @(negedge clk);
    redirect = 1'b0;
    #3;
    chk("co_drop_req", 32'(mem_req), 32'd1);
    chk("co_drop_addr", 32'(mem_addr), 32'h40);
    chk("co_no_push", 32'(instr_valid), 32'd0);
    @(negedge clk);
    ack_grant += 1;
    exp_mem.push_back(8'h80);
    wait_drain("co_reissue");
    chk("co_incr", 32'(incr_cnt - snap), 32'd0);
    @(negedge clk);
    ack_grant += 1;
    expect_instr(8'h80);
    exp_mem.push_back(8'h81);
    wait_drain("co_deliver");
    chk("co_pc", 32'(pc), 32'h81);

    // reset for one cycle while read of 0x81 is outstanding
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_mem.push_back(8'h81);
    #3;
    chk("mr_req", 32'(mem_req), 32'd0);
    chk("mr_valid", 32'(instr_valid), 32'd0);
    chk("mr_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    ack_grant += 1;
    expect_instr(8'h81);
    exp_mem.push_back(8'h82);
    wait_drain("mr_restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
